// File: rtl/trace_active_set_controller.sv
// -----------------------------------------------------------------------------
// trace_active_set_controller
//
// Sequences the trace repository's active set. Entries offered by the
// repository are placed in the lowest free slot. Their memory requests are
// issued one at a time through a shared request port, and each outstanding
// request is tracked by slot id. Completed entries are handed back for
// retirement in lowest-slot-first order.
//
// Each slot follows this lifecycle:
//   FREE -> MAKE_REQUEST -> WAIT_FOR_PROCESSING -> REQUEST_RETIRED -> FREE
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   alloc_valid/ready      repository offers an entry / a FREE slot exists
//   alloc_trace_index      trace index of the offered entry
//   alloc_instruction      instruction word of the offered entry
//   alloc_mem_addr         data address of the offered entry
//   mem_req/gnt            memory request handshake (held stable until grant)
//   mem_addr, mem_tag      address and slot id of the current request
//   mem_rvalid, mem_rtag   memory completion and its slot id
//   retire_valid/ready     retirement handshake with the repository
//   retire_trace_index     trace index of the slot being retired
//   retire_tag             slot id being retired
//   busy_count             number of non-FREE slots
//   protocol_error         sticky flag: a completion arrived for a slot that
//                          was not in WAIT_FOR_PROCESSING
//   stall_count            counts cycles where alloc_valid && !alloc_ready
//
// Build option
//   TRACE_ACTIVE_SET_STALL_CNT_EN  When defined, builds the saturating 32-bit
//                                  stall counter. Otherwise stall_count is
//                                  tied to zero.
//
// Every handshake output is derived from registered state only. Nothing
// passes combinationally from an input to an output.
// -----------------------------------------------------------------------------
module trace_active_set_controller #(
    parameter int ACTIVE_SET_SIZE  = 8,
    parameter int TAG_W            = $clog2(ACTIVE_SET_SIZE),
    parameter int TRACE_ENTRIES    = 2048,
    parameter int TIDX_W           = $clog2(TRACE_ENTRIES),
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int DATA_ADDR_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [TIDX_W-1:0]          alloc_trace_index,
    input  logic [INSTR_DATA_WIDTH-1:0] alloc_instruction,
    input  logic [DATA_ADDR_WIDTH-1:0] alloc_mem_addr,

    output logic                       mem_req,
    input  logic                       mem_gnt,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
    output logic [TAG_W-1:0]           mem_tag,
    input  logic                       mem_rvalid,
    input  logic [TAG_W-1:0]           mem_rtag,

    output logic                       retire_valid,
    input  logic                       retire_ready,
    output logic [TIDX_W-1:0]          retire_trace_index,
    output logic [TAG_W-1:0]           retire_tag,

    output logic [TAG_W:0]             busy_count,
    output logic                       protocol_error,
    output logic [31:0]                stall_count
);

    typedef enum logic [1:0] {
        FREE                = 2'd0,
        MAKE_REQUEST        = 2'd1,
        WAIT_FOR_PROCESSING = 2'd2,
        REQUEST_RETIRED     = 2'd3
    } slot_state_e;

    // Per-slot lifecycle state
    slot_state_e state_q [ACTIVE_SET_SIZE];
    slot_state_e state_d [ACTIVE_SET_SIZE];

    // Per-slot payload
    logic [TIDX_W-1:0]          slot_tidx  [ACTIVE_SET_SIZE];
    logic [DATA_ADDR_WIDTH-1:0] slot_addr  [ACTIVE_SET_SIZE];
    logic [ACTIVE_SET_SIZE-1:0][INSTR_DATA_WIDTH-1:0] slot_instr;

    // Issue arbitration state
    logic [TAG_W-1:0] rr_ptr_q,     rr_ptr_d;
    logic             locked_q,     locked_d;
    logic [TAG_W-1:0] locked_tag_q, locked_tag_d;
    logic             error_q,      error_d;

    // Results of scanning the registered slot states
    logic             free_found;
    logic [TAG_W-1:0] free_idx;
    logic             ret_found;
    logic [TAG_W-1:0] ret_idx;
    logic             pick_found;
    logic [TAG_W-1:0] pick_idx;
    logic [TAG_W:0]   busy_cnt;

    logic [TAG_W-1:0] issue_tag;
    logic             alloc_fire;
    logic             gnt_fire;
    logic             retire_fire;

    // -------------------------------------------------------------------------
    // Scans: lowest FREE slot, lowest RETIRED slot, round-robin MAKE_REQUEST
    // slot, and occupancy count.
    // -------------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default value
    // first. A path that leaves a variable unassigned infers a latch.
    always_comb begin
        logic [TAG_W-1:0] cand;
        free_found = 1'b0;
        free_idx   = '0;
        ret_found  = 1'b0;
        ret_idx    = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        busy_cnt   = '0;
        cand       = '0;
        // Walk downwards so the last match found is the lowest index or
        // the smallest offset from rr_ptr.
        for (int i = ACTIVE_SET_SIZE - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = TAG_W'(i);
            end
            if (state_q[i] == REQUEST_RETIRED) begin
                ret_found = 1'b1;
                ret_idx   = TAG_W'(i);
            end
            // The slot count is a power of two, so the TAG_W-bit sum wraps
            // naturally modulo ACTIVE_SET_SIZE.
            cand = rr_ptr_q + TAG_W'(i);
            if (state_q[cand] == MAKE_REQUEST) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        for (int i = 0; i < ACTIVE_SET_SIZE; i++) begin
            if (state_q[i] != FREE) busy_cnt = busy_cnt + (TAG_W+1)'(1);
        end
    end

    // Once a request has been shown to memory without a grant, the locked
    // tag overrides the arbiter. This keeps mem_addr and mem_tag stable even
    // when new MAKE_REQUEST slots appear.
    assign issue_tag    = locked_q ? locked_tag_q : pick_idx;
    assign mem_req      = locked_q | pick_found;
    assign mem_tag      = mem_req ? issue_tag : '0;
    assign mem_addr     = mem_req ? slot_addr[issue_tag] : '0;

    assign alloc_ready  = free_found;
    assign retire_valid = ret_found;
    assign retire_tag   = ret_found ? ret_idx : '0;
    assign retire_trace_index = ret_found ? slot_tidx[ret_idx] : '0;
    assign busy_count   = busy_cnt;
    assign protocol_error = error_q;

    assign alloc_fire  = alloc_valid & free_found;
    assign gnt_fire    = mem_req & mem_gnt;
    assign retire_fire = ret_found & retire_ready;

    // -------------------------------------------------------------------------
    // Next-state logic. Allocate, grant, complete and retire always act on
    // slots in different states, so all four can update on the same edge
    // without conflict.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < ACTIVE_SET_SIZE; i++) state_d[i] = state_q[i];
        rr_ptr_d     = rr_ptr_q;
        locked_d     = locked_q;
        locked_tag_d = locked_tag_q;
        error_d      = error_q;

        if (alloc_fire) state_d[free_idx] = MAKE_REQUEST;

        if (gnt_fire) begin
            state_d[issue_tag] = WAIT_FOR_PROCESSING;
            rr_ptr_d           = issue_tag + TAG_W'(1);
            locked_d           = 1'b0;
        end else if (mem_req) begin
            locked_d     = 1'b1;
            locked_tag_d = issue_tag;
        end

        // The check uses the registered state. A completion aimed at the
        // slot being granted on this same edge therefore sees MAKE_REQUEST
        // and is flagged as an error.
        if (mem_rvalid) begin
            if (state_q[mem_rtag] == WAIT_FOR_PROCESSING) begin
                state_d[mem_rtag] = REQUEST_RETIRED;
            end else begin
                error_d = 1'b1;
            end
        end

        if (retire_fire) state_d[ret_idx] = FREE;
    end

    // NOTE: sequential state uses non-blocking assignments only. Blocking
    // assignments here would let flops read each other's new values and
    // make the simulation order-dependent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ACTIVE_SET_SIZE; i++) state_q[i] <= FREE;
            rr_ptr_q     <= '0;
            locked_q     <= 1'b0;
            locked_tag_q <= '0;
            error_q      <= 1'b0;
        end else begin
            for (int i = 0; i < ACTIVE_SET_SIZE; i++) state_q[i] <= state_d[i];
            rr_ptr_q     <= rr_ptr_d;
            locked_q     <= locked_d;
            locked_tag_q <= locked_tag_d;
            error_q      <= error_d;
        end
    end

    // NOTE: the payload storage is deliberately left unreset. No output can
    // read a slot's payload unless that slot's state has first been written
    // through allocation, and the slot state itself is reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            slot_tidx[free_idx]  <= alloc_trace_index;
            slot_addr[free_idx]  <= alloc_mem_addr;
            slot_instr[free_idx] <= alloc_instruction;
        end
    end

    // The instruction word is held alongside the entry but no port reads it
    // back. The repository keeps its own copy for retirement.
    logic unused_instr;
    assign unused_instr = ^slot_instr;

`ifdef TRACE_ACTIVE_SET_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (alloc_valid && !free_found && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end
    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_trace_active_set_controller.sv
// -----------------------------------------------------------------------------
// tb_trace_active_set_controller
//
// Self-checking bench for trace_active_set_controller. The reference model
// tracks slot lifecycles, the round-robin pointer and the request lock as
// plain integers. It predicts every output each cycle. Directed sequences
// cover the basic flow, full/stall behaviour, round-robin order, request
// hold, out-of-order completion, protocol errors and asynchronous reset. A
// randomized run follows the directed sequences.
// -----------------------------------------------------------------------------
module tb_trace_active_set_controller;

    localparam int N  = 8;
    localparam int TW = 3;

    localparam int S_FREE = 0;
    localparam int S_MAKE = 1;
    localparam int S_WAIT = 2;
    localparam int S_RET  = 3;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [10:0] alloc_trace_index;
    logic [31:0] alloc_instruction;
    logic [31:0] alloc_mem_addr;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [TW-1:0] mem_tag;
    logic        mem_rvalid;
    logic [TW-1:0] mem_rtag;
    logic        retire_valid;
    logic        retire_ready;
    logic [10:0] retire_trace_index;
    logic [TW-1:0] retire_tag;
    logic [TW:0] busy_count;
    logic        protocol_error;
    logic [31:0] stall_count;

    trace_active_set_controller dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alloc_valid        (alloc_valid),
        .alloc_ready        (alloc_ready),
        .alloc_trace_index  (alloc_trace_index),
        .alloc_instruction  (alloc_instruction),
        .alloc_mem_addr     (alloc_mem_addr),
        .mem_req            (mem_req),
        .mem_gnt            (mem_gnt),
        .mem_addr           (mem_addr),
        .mem_tag            (mem_tag),
        .mem_rvalid         (mem_rvalid),
        .mem_rtag           (mem_rtag),
        .retire_valid       (retire_valid),
        .retire_ready       (retire_ready),
        .retire_trace_index (retire_trace_index),
        .retire_tag         (retire_tag),
        .busy_count         (busy_count),
        .protocol_error     (protocol_error),
        .stall_count        (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    int          m_state [N];
    logic [10:0] m_tidx  [N];
    logic [31:0] m_addr  [N];
    int          m_rr;
    bit          m_locked;
    int          m_lock_tag;
    bit          m_err;
    longint      m_stall;

    bit e_alloc_ready;
    int e_free;
    bit e_req;
    int e_tag;
    bit e_ret_valid;
    int e_ret;
    int e_busy;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = S_FREE;
            m_tidx[i]  = '0;
            m_addr[i]  = '0;
        end
        m_rr = 0; m_locked = 0; m_lock_tag = 0; m_err = 0; m_stall = 0;
    endfunction

    function automatic void model_eval();
        e_alloc_ready = 0; e_free = 0;
        e_ret_valid = 0;   e_ret = 0;
        e_busy = 0;
        for (int i = 0; i < N; i++) begin
            if (m_state[i] == S_FREE && !e_alloc_ready) begin e_alloc_ready = 1; e_free = i; end
            if (m_state[i] == S_RET && !e_ret_valid) begin e_ret_valid = 1; e_ret = i; end
            if (m_state[i] != S_FREE) e_busy++;
        end
        e_req = 0; e_tag = 0;
        if (m_locked) begin
            e_req = 1; e_tag = m_lock_tag;
        end else begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_rr + k) % N;
                if (!e_req && m_state[s] == S_MAKE) begin e_req = 1; e_tag = s; end
            end
        end
    endfunction

    // Applies one clock edge to the model, using the inputs as driven.
    function automatic void model_edge();
        int pre [N];
        model_eval();
        pre = m_state;
        if (alloc_valid && e_alloc_ready) begin
            m_state[e_free] = S_MAKE;
            m_tidx[e_free]  = alloc_trace_index;
            m_addr[e_free]  = alloc_mem_addr;
        end
        if (e_req) begin
            if (mem_gnt) begin
                m_state[e_tag] = S_WAIT;
                m_rr = (e_tag + 1) % N;
                m_locked = 0;
            end else begin
                m_locked = 1;
                m_lock_tag = e_tag;
            end
        end
        if (mem_rvalid) begin
            if (pre[int'(mem_rtag)] == S_WAIT) m_state[int'(mem_rtag)] = S_RET;
            else m_err = 1;
        end
        if (e_ret_valid && retire_ready) m_state[e_ret] = S_FREE;
`ifdef TRACE_ACTIVE_SET_STALL_CNT_EN
        if (alloc_valid && !e_alloc_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
    endfunction

    task automatic check_outputs();
        model_eval();
        check("alloc_ready", 64'(alloc_ready), 64'(e_alloc_ready));
        check("mem_req", 64'(mem_req), 64'(e_req));
        check("mem_tag", 64'(mem_tag), e_req ? 64'(e_tag) : 64'd0);
        check("mem_addr", 64'(mem_addr), e_req ? 64'(m_addr[e_tag]) : 64'd0);
        check("retire_valid", 64'(retire_valid), 64'(e_ret_valid));
        check("retire_tag", 64'(retire_tag), e_ret_valid ? 64'(e_ret) : 64'd0);
        check("retire_tidx", 64'(retire_trace_index), e_ret_valid ? 64'(m_tidx[e_ret]) : 64'd0);
        check("busy_count", 64'(busy_count), 64'(e_busy));
        check("protocol_error", 64'(protocol_error), 64'(m_err));
        check("stall_count", 64'(stall_count), 64'(m_stall));
    endtask

    // Called just after a falling edge with the inputs already driven.
    task automatic cycle();
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; mem_gnt = 0; mem_rvalid = 0; mem_rtag = '0; retire_ready = 0;
    endtask

    task automatic rand_payload();
        alloc_trace_index = 11'($urandom);
        alloc_instruction = $urandom;
        alloc_mem_addr    = $urandom;
    endtask

    // Asserts reset in the middle of a cycle and checks that the outputs
    // clear without waiting for a clock edge.
    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        alloc_trace_index = '0; alloc_instruction = '0; alloc_mem_addr = '0;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // ---- basic flow: index 5, addr 0x100
        alloc_valid = 1; alloc_trace_index = 11'd5; alloc_mem_addr = 32'h100;
        alloc_instruction = 32'h1234_5678;
        cycle();
        alloc_valid = 0;
        check("t1_req", 64'(mem_req), 64'd1);
        check("t1_tag", 64'(mem_tag), 64'd0);
        check("t1_addr", 64'(mem_addr), 64'h100);
        mem_gnt = 1; cycle(); mem_gnt = 0;
        mem_rvalid = 1; mem_rtag = 3'd0; cycle(); mem_rvalid = 0;
        check("t1_rvalid", 64'(retire_valid), 64'd1);
        check("t1_rtidx", 64'(retire_trace_index), 64'd5);
        retire_ready = 1; cycle(); retire_ready = 0;
        check("t1_busy", 64'(busy_count), 64'd0);

        // ---- fill all slots without grants, then stall
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < N; i++) begin rand_payload(); cycle(); end
        check("t2_full_ready", 64'(alloc_ready), 64'd0);
        check("t2_full_busy", 64'(busy_count), 64'd8);
        for (int i = 0; i < 3; i++) cycle();
        alloc_valid = 0;
`ifdef TRACE_ACTIVE_SET_STALL_CNT_EN
        check("t2_stall", 64'(stall_count), 64'd3);
`else
        check("t2_stall", 64'(stall_count), 64'd0);
`endif

        // ---- round-robin order
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 5; i++) begin rand_payload(); cycle(); end
        alloc_valid = 0;
        mem_gnt = 1;
        for (int k = 0; k < 3; k++) begin
            check("t3_tag_a", 64'(mem_tag), 64'(k));
            cycle();
        end
        mem_gnt = 0;
        mem_rvalid = 1; mem_rtag = 3'd0; cycle(); mem_rvalid = 0;
        retire_ready = 1; cycle(); retire_ready = 0;
        alloc_valid = 1; rand_payload(); cycle(); alloc_valid = 0;
        mem_gnt = 1;
        check("t3_tag_3", 64'(mem_tag), 64'd3); cycle();
        check("t3_tag_4", 64'(mem_tag), 64'd4); cycle();
        check("t3_tag_0", 64'(mem_tag), 64'd0); cycle();
        mem_gnt = 0;

        // ---- request held stable while grant is low
        do_reset();
        alloc_valid = 1; alloc_trace_index = 11'd9; alloc_mem_addr = 32'hDEAD_0000;
        cycle();
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            check("t4_req", 64'(mem_req), 64'd1);
            check("t4_addr", 64'(mem_addr), 64'hDEAD_0000);
            check("t4_tag", 64'(mem_tag), 64'd0);
            cycle();
        end
        alloc_valid = 0;

        // ---- out-of-order completions, in-order retirement
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 3; i++) begin rand_payload(); cycle(); end
        alloc_valid = 0;
        mem_gnt = 1;
        for (int i = 0; i < 3; i++) cycle();
        mem_gnt = 0;
        mem_rvalid = 1;
        mem_rtag = 3'd2; cycle();
        mem_rtag = 3'd0; cycle();
        mem_rtag = 3'd1; cycle();
        mem_rvalid = 0;
        check("t5_busy", 64'(busy_count), 64'd3);
        check("t5_perr", 64'(protocol_error), 64'd0);
        retire_ready = 1;
        for (int k = 0; k < 3; k++) begin
            check("t5_rtag", 64'(retire_tag), 64'(k));
            cycle();
        end
        retire_ready = 0;
        check("t5_empty", 64'(busy_count), 64'd0);

        // ---- completion for a FREE slot, then asynchronous reset
        do_reset();
        mem_rvalid = 1; mem_rtag = 3'd6; cycle(); mem_rvalid = 0;
        check("t6_perr", 64'(protocol_error), 64'd1);
        alloc_valid = 1;
        for (int i = 0; i < 3; i++) begin rand_payload(); cycle(); end
        alloc_valid = 0;
        check("t6_perr_sticky", 64'(protocol_error), 64'd1);
        do_reset();
        check("t6_perr_clr", 64'(protocol_error), 64'd0);
        check("t6_ready", 64'(alloc_ready), 64'd1);

        // ---- completion on the slot being granted in the same cycle
        alloc_valid = 1; rand_payload(); cycle(); alloc_valid = 0;
        mem_gnt = 1; mem_rvalid = 1; mem_rtag = 3'd0; cycle();
        mem_gnt = 0; mem_rvalid = 0;
        check("t7_same_cycle_perr", 64'(protocol_error), 64'd1);

        // ---- randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int waits[$];
            alloc_valid  = 1'($urandom_range(1, 0));
            rand_payload();
            mem_gnt      = ($urandom_range(9, 0) < 4);
            retire_ready = 1'($urandom_range(1, 0));
            mem_rvalid   = 0;
            mem_rtag     = '0;
            waits.delete();
            for (int i = 0; i < N; i++) if (m_state[i] == S_WAIT) waits.push_back(i);
            if (waits.size() > 0 && $urandom_range(1, 0) == 1) begin
                mem_rvalid = 1;
                mem_rtag   = TW'(waits[$urandom_range(waits.size() - 1, 0)]);
            end
            cycle();
        end
        idle_inputs();
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
